// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller.
// Holds the display codes that the HEX-digit decoders understand, the legal
// die value range, and the roller FSM state encoding.
package dice_pkg;

   localparam logic [7:0] DISP_BLANK = 8'd99;
   localparam logic [7:0] DISP_DASH  = 8'hBF;
   localparam logic [2:0] DIE_MIN    = 3'd1;
   localparam logic [2:0] DIE_MAX    = 3'd6;

   typedef enum logic [1:0] {
      IDLE,
      ROLLING,
      SHOW
   } state_t;

endpackage

// File: rtl/button_conditioner.sv
// Roll push-button conditioner.
// Synchronizes the raw active-low button, debounces it and emits a one-cycle
// press pulse on each accepted 1->0 transition of the debounced level.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   btn_n  : raw asynchronous active-low button
//   press  : registered one-cycle pulse per accepted press
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // Down-counter reloads whenever the synchronized input agrees with the
   // debounced level, so only an unbroken run of disagreeing cycles reaches 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= CNT_LOAD;
         press <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= CNT_LOAD;
         end else if (cnt == '0) begin
            level <= sync2;
            cnt   <= CNT_LOAD;
            press <= ~sync2;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/dice_roller.sv
// Dice roller: conditions the roll button, animates a timed roll and settles
// two dice on values 1..6 for the HEX-digit decoders.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   roll_n    : raw active-low roll button
//   clr       : synchronous clean level, forces IDLE
//   die0_num  : display code for die 0 (1..6 or dash)
//   die1_num  : display code for die 1 (1..6 or dash)
//   rolling   : high while the animation runs
//   done      : one-cycle pulse when a roll settles
//
// state   | meaning
// IDLE    | no roll yet or cleared; both dice show the dash code
// ROLLING | animation running; dice relatched from entropy every tick
// SHOW    | roll settled; dice held until the next press
module dice_roller
   import dice_pkg::*;
#(
   parameter int TICK_DIV        = 5000000,
   parameter int ROLL_TICKS      = 20,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       roll_n,
   input  logic       clr,
   output logic [7:0] die0_num,
   output logic [7:0] die1_num,
   output logic       rolling,
   output logic       done
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int RW = $clog2(ROLL_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [RW-1:0] ROLL_LOAD = RW'(ROLL_TICKS);

   state_t        state;
   state_t        state_nxt;
   logic          press;
   logic [2:0]    c0;
   logic [2:0]    c1;
   logic [TW-1:0] tick_cnt;
   logic [TW-1:0] tick_nxt;
   logic [RW-1:0] remaining;
   logic [RW-1:0] rem_nxt;
   logic [7:0]    die0_nxt;
   logic [7:0]    die1_nxt;
   logic          done_nxt;
   logic          tick;
   logic          settle;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn_n (roll_n),
      .press (press)
   );

   // Free-running entropy: the press instant relative to these counters is
   // what makes the outcome unpredictable to the player.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c0 <= DIE_MIN;
         c1 <= DIE_MIN;
      end else begin
         c0 <= (c0 == DIE_MAX) ? DIE_MIN : c0 + 3'd1;
         if (c0 == DIE_MAX) begin
            c1 <= (c1 == DIE_MAX) ? DIE_MIN : c1 + 3'd1;
         end
      end
   end

   assign tick    = (state == ROLLING) && (tick_cnt == TICK_LAST);
   assign settle  = tick && (remaining == RW'(1));
   assign rolling = (state == ROLLING);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (press)  state_nxt = ROLLING;
            ROLLING: if (settle) state_nxt = SHOW;
            SHOW:    if (press)  state_nxt = ROLLING;
            default:             state_nxt = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs and roll timers. The IDLE branch
   // comes first so clr also swallows a coincident settle and its done.
   always_comb begin
      die0_nxt = die0_num;
      die1_nxt = die1_num;
      tick_nxt = tick_cnt;
      rem_nxt  = remaining;
      done_nxt = 1'b0;
      if (state_nxt == IDLE) begin
         die0_nxt = DISP_DASH;
         die1_nxt = DISP_DASH;
         tick_nxt = '0;
         rem_nxt  = '0;
      end else if (state != ROLLING && state_nxt == ROLLING) begin
         die0_nxt = {5'd0, c0};
         die1_nxt = {5'd0, c1};
         tick_nxt = '0;
         rem_nxt  = ROLL_LOAD;
      end else if (state == ROLLING) begin
         if (tick) begin
            die0_nxt = {5'd0, c0};
            die1_nxt = {5'd0, c1};
            tick_nxt = '0;
            rem_nxt  = remaining - 1'b1;
            done_nxt = settle;
         end else begin
            tick_nxt = tick_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         die0_num  <= DISP_DASH;
         die1_num  <= DISP_DASH;
         tick_cnt  <= '0;
         remaining <= '0;
         done      <= 1'b0;
      end else begin
         die0_num  <= die0_nxt;
         die1_num  <= die1_nxt;
         tick_cnt  <= tick_nxt;
         remaining <= rem_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with TICK_DIV=4, ROLL_TICKS=3,
// DEBOUNCE_CYCLES=2. Inputs change and outputs are sampled on the falling
// clock edge. Expected die values come from closed-form counter formulas
// indexed by the number of rising edges since reset release.
module tb_dice_roller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       roll_n = 1'b1;
   logic       clr = 1'b0;
   logic [7:0] die0_num;
   logic [7:0] die1_num;
   logic       rolling;
   logic       done;

   int vectors = 0;
   int miscompares = 0;
   int n_edge;

   localparam int DASH = 191;

   dice_roller #(
      .TICK_DIV        (4),
      .ROLL_TICKS      (3),
      .DEBOUNCE_CYCLES (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .roll_n   (roll_n),
      .clr      (clr),
      .die0_num (die0_num),
      .die1_num (die1_num),
      .rolling  (rolling),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Rising edges since reset release; edge index N = n_edge-1 once sampled.
   always @(posedge clk or posedge rst) begin
      if (rst) n_edge <= 0;
      else     n_edge <= n_edge + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // c0/c1 values present just before rising edge n.
   function automatic int c0_before(input int n);
      return (n % 6) + 1;
   endfunction

   function automatic int c1_before(input int n);
      return ((n / 6) % 6) + 1;
   endfunction

   // Press the button and wait for ROLLING; the button stays low.
   task automatic start_roll(input string tag);
      int k;
      k = 0;
      roll_n = 1'b0;
      while (k < 20 && !rolling) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_press_lat"}, k, 5);
      check({tag, "_entry_d0"}, int'(die0_num), c0_before(n_edge - 1));
      check({tag, "_entry_d1"}, int'(die1_num), c1_before(n_edge - 1));
   endtask

   // Wait for done after entry; rel_at releases the button, press_at (>0)
   // drives a second press during the roll.
   task automatic finish_roll(input string tag, input int rel_at, input int press_at);
      int m;
      bit in_range;
      m = 0;
      in_range = 1'b1;
      if (rel_at == 0) roll_n = 1'b1;
      while (m < 30) begin
         @(negedge clk);
         m++;
         if (m == rel_at) roll_n = 1'b1;
         if (press_at > 0 && m == press_at) roll_n = 1'b0;
         if (press_at > 0 && m == press_at + 6) roll_n = 1'b1;
         if (die0_num < 8'd1 || die0_num > 8'd6 || die1_num < 8'd1 || die1_num > 8'd6)
            in_range = 1'b0;
         if (done) break;
      end
      check({tag, "_done_lat"}, m, 12);
      check({tag, "_final_d0"}, int'(die0_num), c0_before(n_edge - 1));
      check({tag, "_final_d1"}, int'(die1_num), c1_before(n_edge - 1));
      check({tag, "_rolling_off"}, int'(rolling), 0);
      check({tag, "_range"}, int'(in_range), 1);
      roll_n = 1'b1;
      @(negedge clk);
      check({tag, "_done_width"}, int'(done), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int rises;
      int dones;
      int roll_seen;
      bit prev;

      repeat (3) @(negedge clk);
      check("rst_d0", int'(die0_num), DASH);
      check("rst_d1", int'(die1_num), DASH);
      check("rst_rolling", int'(rolling), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("c0_free", int'(dut.c0), (n_edge % 6) + 1);
      end
      check("idle_d0", int'(die0_num), DASH);
      check("idle_d1", int'(die1_num), DASH);

      // Single roll with the button held 10 cycles.
      start_roll("single");
      finish_roll("single", 5, 0);

      // clr from SHOW.
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_show_d0", int'(die0_num), DASH);
      check("clr_show_rolling", int'(rolling), 0);

      // Bounce: one-cycle glitches never pass a 2-cycle debounce.
      for (int i = 0; i < 8; i++) begin
         roll_n = ~roll_n;
         @(negedge clk);
      end
      roll_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rolling) roll_seen++;
      end
      check("bounce_rolling", roll_seen, 0);
      check("bounce_d0", int'(die0_num), DASH);

      // Long hold gives one roll only.
      roll_n = 1'b0;
      rises = 0;
      dones = 0;
      prev = rolling;
      for (int i = 0; i < 108; i++) begin
         if (i == 100) roll_n = 1'b1;
         @(negedge clk);
         if (rolling && !prev) rises++;
         if (done) dones++;
         prev = rolling;
      end
      check("hold_rolls", rises, 1);
      check("hold_dones", dones, 1);

      // Second press mid-roll is ignored.
      start_roll("midpress");
      finish_roll("midpress", 0, 5);
      roll_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rolling) roll_seen++;
      end
      check("midpress_no_restart", roll_seen, 0);

      // Re-roll from SHOW.
      start_roll("reroll");
      finish_roll("reroll", 1, 0);

      // clr during ROLLING.
      start_roll("clrroll");
      roll_n = 1'b1;
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clrroll_d0", int'(die0_num), DASH);
      check("clrroll_d1", int'(die1_num), DASH);
      check("clrroll_rolling", int'(rolling), 0);
      check("clrroll_done", int'(done), 0);
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || rolling) dones++;
      end
      check("clrroll_quiet", dones, 0);

      // clr coincident with the final tick (edge entry+12).
      start_roll("clrfin");
      roll_n = 1'b1;
      repeat (11) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clrfin_done", int'(done), 0);
      check("clrfin_rolling", int'(rolling), 0);
      check("clrfin_d0", int'(die0_num), DASH);
      @(negedge clk);
      check("clrfin_done_late", int'(done), 0);

      // Asynchronous reset mid-roll.
      start_roll("rstroll");
      roll_n = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstroll_d0", int'(die0_num), DASH);
      check("rstroll_d1", int'(die1_num), DASH);
      check("rstroll_rolling", int'(rolling), 0);
      check("rstroll_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || rolling) dones++;
      end
      check("rstroll_quiet", dones, 0);
      check("rstroll_c0", int'(dut.c0), (n_edge % 6) + 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
